// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: stall/flush sequencer for the 5-stage RV32I pipeline.
// Handles load-use, mispredict, data-memory waits with timeout, and trap entry.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ID_rs1,
  input  logic [4:0] ID_rs2,
  input  logic       ID_rs1_used,
  input  logic       ID_rs2_used,
  input  logic       EX_memory_read,
  input  logic [4:0] EX_rd,
  input  logic       EX_mispredict,
  input  logic       MEM_memory_read,
  input  logic       MEM_memory_write,
  input  logic       dmem_ready,
  input  logic       trap_request,
  input  logic       trap_done,
  output logic       pc_stall,
  output logic       IF_ID_stall,
  output logic       IF_ID_flush,
  output logic       ID_EX_stall,
  output logic       ID_EX_flush,
  output logic       EX_MEM_stall,
  output logic       EX_MEM_flush,
  output logic       MEM_WB_flush,
  output logic       trap_ack,
  output logic       trap_redirect,
  output logic       bus_error,
  output logic [1:0] ctrl_state
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP_FLUSH, TRAP_WAIT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic load_use, mem_busy, timeout, hold, run_like, mp, lu, tf, tw;
  assign load_use = EX_memory_read && EX_rd != 5'd0 &&
                    ((ID_rs1_used && ID_rs1 == EX_rd) || (ID_rs2_used && ID_rs2 == EX_rd));
  assign mem_busy = (MEM_memory_read || MEM_memory_write) && !dmem_ready;
  assign timeout  = state == MEM_WAIT && !dmem_ready && cnt == CW'(MEM_TIMEOUT);
  // The ready cycle of a wait behaves like RUN so a held mispredict or load-use is not dropped
  assign hold     = !reset && ((state == RUN && !trap_request && mem_busy) ||
                               (state == MEM_WAIT && !dmem_ready));
  assign run_like = !reset && ((state == RUN && !trap_request && !mem_busy) ||
                               (state == MEM_WAIT && dmem_ready));
  assign mp = run_like && EX_mispredict;
  assign lu = run_like && !EX_mispredict && load_use;
  assign tf = !reset && state == TRAP_FLUSH;
  assign tw = !reset && state == TRAP_WAIT;
  assign pc_stall      = hold || lu || tf || (tw && !trap_done);
  assign IF_ID_stall   = hold || lu;
  assign IF_ID_flush   = mp || tf || tw;
  assign ID_EX_stall   = hold;
  assign ID_EX_flush   = mp || lu || tf || tw;
  assign EX_MEM_stall  = hold;
  assign EX_MEM_flush  = tf;
  assign MEM_WB_flush  = hold || tf;
  assign trap_ack      = !reset && state == RUN && trap_request;
  assign trap_redirect = tw && trap_done;
  assign bus_error     = !reset && timeout;
  assign ctrl_state    = state;
  always_comb begin
    state_nxt = state == RUN        ? (trap_request ? TRAP_FLUSH : mem_busy ? MEM_WAIT : RUN) :
                state == MEM_WAIT   ? (dmem_ready ? RUN : timeout ? TRAP_FLUSH : MEM_WAIT) :
                state == TRAP_FLUSH ? TRAP_WAIT :
                                      (trap_done ? RUN : TRAP_WAIT);
    cnt_nxt   = (state == RUN && !trap_request && mem_busy) ? CW'(1) :
                (state == MEM_WAIT && !dmem_ready && !timeout) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;
  localparam int T = 4;
  localparam logic [10:0] PCS = 11'h400, IFS = 11'h200, IFF = 11'h100, IDS = 11'h080,
                          IDF = 11'h040, EXS = 11'h020, EXF = 11'h010, MWF = 11'h008,
                          ACK = 11'h004, RED = 11'h002, BER = 11'h001;
  localparam logic [10:0] HOLD = PCS | IFS | IDS | EXS | MWF;
  localparam logic [10:0] ALLF = PCS | IFF | IDF | EXF | MWF;
  logic clk = 0, reset = 1;
  logic [4:0] ID_rs1, ID_rs2, EX_rd;
  logic ID_rs1_used, ID_rs2_used, EX_memory_read, EX_mispredict;
  logic MEM_memory_read, MEM_memory_write, dmem_ready, trap_request, trap_done;
  logic pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush, EX_MEM_stall;
  logic EX_MEM_flush, MEM_WB_flush, trap_ack, trap_redirect, bus_error;
  logic [1:0] ctrl_state;
  int checks = 0, failures = 0;
  int m_mode = 0, m_wait = 0;
  logic [12:0] last_exp;
  bit trq = 0;

  pipeline_hazard_controller #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .EX_memory_read(EX_memory_read), .EX_rd(EX_rd), .EX_mispredict(EX_mispredict),
    .MEM_memory_read(MEM_memory_read), .MEM_memory_write(MEM_memory_write),
    .dmem_ready(dmem_ready), .trap_request(trap_request), .trap_done(trap_done),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
    .EX_MEM_flush(EX_MEM_flush), .MEM_WB_flush(MEM_WB_flush), .trap_ack(trap_ack),
    .trap_redirect(trap_redirect), .bus_error(bus_error), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] dut_out();
    return {ctrl_state, pc_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
            EX_MEM_stall, EX_MEM_flush, MEM_WB_flush, trap_ack, trap_redirect, bus_error};
  endfunction

  function automatic logic [12:0] model();
    logic [10:0] o = '0;
    bit lu, busy;
    if (reset) return '0;
    lu = EX_memory_read && EX_rd != 0 &&
         ((ID_rs1_used && ID_rs1 == EX_rd) || (ID_rs2_used && ID_rs2 == EX_rd));
    busy = (MEM_memory_read || MEM_memory_write) && !dmem_ready;
    case (m_mode)
      0: o = trap_request ? ACK : busy ? HOLD : EX_mispredict ? (IFF | IDF) :
             lu ? (PCS | IFS | IDF) : '0;
      1: o = dmem_ready ? (EX_mispredict ? (IFF | IDF) : lu ? (PCS | IFS | IDF) : '0)
                        : (HOLD | (m_wait == T ? BER : '0));
      2: o = ALLF;
      default: o = trap_done ? (IFF | IDF | RED) : (PCS | IFF | IDF);
    endcase
    return {2'(m_mode), o};
  endfunction

  task automatic advance_model();
    bit busy;
    busy = (MEM_memory_read || MEM_memory_write) && !dmem_ready;
    if (reset) begin
      m_mode = 0; m_wait = 0;
    end else case (m_mode)
      0: if (trap_request) m_mode = 2; else if (busy) begin m_mode = 1; m_wait = 1; end
      1: if (dmem_ready) begin m_mode = 0; m_wait = 0; end
         else if (m_wait == T) begin m_mode = 2; m_wait = 0; end
         else m_wait++;
      2: m_mode = 3;
      default: if (trap_done) m_mode = 0;
    endcase
  endtask

  task automatic cmp(input string nm, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
               nm, got[12:11], got[10:0], exp[12:11], exp[10:0]);
    end
  endtask

  task automatic step(input string nm, input bit use_lit, input logic [12:0] lit);
    @(negedge clk);
    last_exp = model();
    cmp({nm, "/model"}, dut_out(), last_exp);
    if (use_lit) cmp(nm, dut_out(), lit);
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs1 = 0; ID_rs2 = 0; EX_rd = 0; ID_rs1_used = 0; ID_rs2_used = 0;
    EX_memory_read = 0; EX_mispredict = 0; MEM_memory_read = 0; MEM_memory_write = 0;
    dmem_ready = 0; trap_request = 0; trap_done = 0;
  endtask

  initial begin
    idle();
    step("reset", 1, 13'h0);
    reset = 0;
    // load-use on rs1, then the same with EX_rd = x0
    EX_memory_read = 1; EX_rd = 5; ID_rs1 = 5; ID_rs1_used = 1;
    step("load_use", 1, {2'd0, PCS | IFS | IDF});
    EX_rd = 0; ID_rs1 = 0;
    step("load_use_x0", 1, 13'h0);
    EX_rd = 7; ID_rs2 = 7; ID_rs2_used = 1; ID_rs1_used = 0; EX_mispredict = 1;
    step("lu_and_mispredict", 1, {2'd0, IFF | IDF});
    idle();
    // three cycles of dmem_ready low, then ready
    MEM_memory_read = 1;
    step("mem_busy_run", 1, {2'd0, HOLD});
    step("mem_wait1", 1, {2'd1, HOLD});
    step("mem_wait2", 1, {2'd1, HOLD});
    dmem_ready = 1;
    step("mem_ready", 1, {2'd1, 11'h0});
    idle();
    step("back_run", 1, 13'h0);
    // timeout path
    MEM_memory_write = 1;
    step("to_run", 1, {2'd0, HOLD});
    step("to_w1", 1, {2'd1, HOLD});
    step("to_w2", 1, {2'd1, HOLD});
    step("to_w3", 1, {2'd1, HOLD});
    step("to_bus_error", 1, {2'd1, HOLD | BER});
    trap_done = 1;
    step("to_trap_flush", 1, {2'd2, ALLF});
    idle();
    step("to_trap_wait", 1, {2'd3, PCS | IFF | IDF});
    trap_done = 1;
    step("to_redirect", 1, {2'd3, IFF | IDF | RED});
    idle();
    step("to_run_again", 1, 13'h0);
    // trap entry from RUN
    trap_request = 1;
    step("trap_ack", 1, {2'd0, ACK});
    trap_request = 0;
    step("trap_flush", 1, {2'd2, ALLF});
    step("trap_wait1", 1, {2'd3, PCS | IFF | IDF});
    step("trap_wait2", 1, {2'd3, PCS | IFF | IDF});
    trap_done = 1;
    step("trap_redirect", 1, {2'd3, IFF | IDF | RED});
    trap_done = 0;
    step("trap_run", 1, 13'h0);
    // asynchronous reset mid-wait
    MEM_memory_read = 1;
    step("rw_run", 1, {2'd0, HOLD});
    step("rw_w1", 1, {2'd1, HOLD});
    reset = 1;
    #1;
    cmp("async_reset", dut_out(), 13'h0);
    m_mode = 0; m_wait = 0;
    step("reset_hold", 1, 13'h0);
    reset = 0;
    step("rw2_run", 1, {2'd0, HOLD});
    step("rw2_w1", 1, {2'd1, HOLD});
    step("rw2_w2", 1, {2'd1, HOLD});
    step("rw2_w3", 1, {2'd1, HOLD});
    step("rw2_bus_error", 1, {2'd1, HOLD | BER});
    idle();
    step("rw2_flush", 1, {2'd2, ALLF});
    trap_done = 1;
    step("rw2_redirect", 1, {2'd3, IFF | IDF | RED});
    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      ID_rs1 = 5'($urandom_range(0, 3)); ID_rs2 = 5'($urandom_range(0, 3));
      EX_rd = 5'($urandom_range(0, 3));
      ID_rs1_used = 1'($urandom); ID_rs2_used = 1'($urandom);
      EX_memory_read = 1'($urandom); EX_mispredict = ($urandom % 4) == 0;
      MEM_memory_read = ($urandom % 3) == 0; MEM_memory_write = ($urandom % 4) == 0;
      dmem_ready = ($urandom % 5) < 2; trap_done = ($urandom % 3) == 0;
      reset = ($urandom % 300) == 0;
      trap_request = trq;
      step("random", 0, 13'h0);
      if (last_exp[2]) trq = 0;
      else if (!trq && ($urandom % 12) == 0) trq = 1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
